// File: rtl/memory_arbiter_if.sv
// Bundle of requester channels (CPU, loader, save engine) and the memory
// controller command/response link used by memory_arbiter.
interface memory_arbiter_if #(
  parameter int unsigned ADDR_W = 25
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rnw;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ack;

  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_din;
  logic              ldr_ack;

  logic              sav_req;
  logic [ADDR_W-1:0] sav_addr;
  logic              sav_rnw;
  logic [7:0]        sav_din;
  logic [7:0]        sav_dout;
  logic              sav_ack;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ack;

  logic              err_timeout;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_addr, cpu_rnw, cpu_din,
    output cpu_dout, cpu_ack,
    input  ldr_req, ldr_addr, ldr_din,
    output ldr_ack,
    input  sav_req, sav_addr, sav_rnw, sav_din,
    output sav_dout, sav_ack,
    output mem_req, mem_addr, mem_we, mem_din,
    input  mem_dout, mem_ack,
    output err_timeout
  );

  // Requesters plus memory controller side
  modport master (
    output cpu_req, cpu_addr, cpu_rnw, cpu_din,
    input  cpu_dout, cpu_ack,
    output ldr_req, ldr_addr, ldr_din,
    input  ldr_ack,
    output sav_req, sav_addr, sav_rnw, sav_din,
    input  sav_dout, sav_ack,
    input  mem_req, mem_addr, mem_we, mem_din,
    output mem_dout, mem_ack,
    input  err_timeout
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-transaction arbiter sharing cartridge memory between CPU, ROM loader
// and SRAM save engine: CPU-first with starvation guard, loader/save round-robin.
module memory_arbiter #(
  parameter int unsigned ADDR_W        = 25,
  parameter int unsigned CPU_BURST_MAX = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  memory_arbiter_if.slave     arb_if
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned STREAK_W = $clog2(CPU_BURST_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {G_CPU, G_LDR, G_SAV} gnt_e;

  state_e              state_q, state_d;
  gnt_e                gnt_q, gnt_d, gnt_sel;
  logic                rr_q, rr_d;          // 0: loader is next, 1: save is next
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          mem_din_q, mem_din_d;

  logic                cpu_ack_q, cpu_ack_d;
  logic                ldr_ack_q, ldr_ack_d;
  logic                sav_ack_q, sav_ack_d;
  logic [7:0]          cpu_dout_q, cpu_dout_d;
  logic [7:0]          sav_dout_q, sav_dout_d;
  logic                err_q, err_d;

  logic                lower_req;
  logic                any_req;
  logic                cpu_wins;
  logic                tmo_hit;
  logic [7:0]          cpl_data;

  // Grant selection seen from IDLE
  always_comb begin
    lower_req = arb_if.ldr_req | arb_if.sav_req;
    any_req   = arb_if.cpu_req | lower_req;
    cpu_wins  = arb_if.cpu_req &&
                !((streak_q == STREAK_W'(CPU_BURST_MAX)) && lower_req);
    gnt_sel   = G_CPU;
    if (!cpu_wins) begin
      if (arb_if.ldr_req && arb_if.sav_req) begin
        gnt_sel = rr_q ? G_SAV : G_LDR;
      end else if (arb_if.sav_req) begin
        gnt_sel = G_SAV;
      end else begin
        gnt_sel = G_LDR;
      end
    end
    // Ack in the same cycle the counter would reach TIMEOUT still wins
    tmo_hit  = (cnt_q == CNT_W'(TIMEOUT - 1)) && !arb_if.mem_ack;
    cpl_data = arb_if.mem_ack ? arb_if.mem_dout : 8'hFF;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any_req) state_d = S_BUSY;
      S_BUSY: if (arb_if.mem_ack || tmo_hit) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    streak_d   = lower_req ? streak_q : '0;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = mem_we_q;
    mem_din_d  = mem_din_q;
    cpu_ack_d  = 1'b0;
    ldr_ack_d  = 1'b0;
    sav_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    sav_dout_d = sav_dout_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d     = gnt_sel;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          unique case (gnt_sel)
            G_CPU: begin
              mem_addr_d = arb_if.cpu_addr;
              mem_we_d   = ~arb_if.cpu_rnw;
              mem_din_d  = arb_if.cpu_din;
              if (lower_req && (streak_q != STREAK_W'(CPU_BURST_MAX))) begin
                streak_d = streak_q + STREAK_W'(1);
              end
            end
            G_LDR: begin
              mem_addr_d = arb_if.ldr_addr;
              mem_we_d   = 1'b1;
              mem_din_d  = arb_if.ldr_din;
              rr_d       = 1'b1;
              streak_d   = '0;
            end
            default: begin
              mem_addr_d = arb_if.sav_addr;
              mem_we_d   = ~arb_if.sav_rnw;
              mem_din_d  = arb_if.sav_din;
              rr_d       = 1'b0;
              streak_d   = '0;
            end
          endcase
        end
      end
      S_BUSY: begin
        if (arb_if.mem_ack || tmo_hit) begin
          mem_req_d = 1'b0;
          if (tmo_hit) err_d = 1'b1;
          unique case (gnt_q)
            G_CPU: begin
              cpu_ack_d  = 1'b1;
              cpu_dout_d = cpl_data;
            end
            G_LDR: ldr_ack_d = 1'b1;
            default: begin
              sav_ack_d  = 1'b1;
              sav_dout_d = cpl_data;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= G_CPU;
      rr_q       <= 1'b0;
      streak_q   <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
      cpu_ack_q  <= 1'b0;
      ldr_ack_q  <= 1'b0;
      sav_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      sav_dout_q <= '0;
      err_q      <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      streak_q   <= streak_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      cpu_ack_q  <= cpu_ack_d;
      ldr_ack_q  <= ldr_ack_d;
      sav_ack_q  <= sav_ack_d;
      cpu_dout_q <= cpu_dout_d;
      sav_dout_q <= sav_dout_d;
      err_q      <= err_d;
    end
  end

  assign arb_if.mem_req     = mem_req_q;
  assign arb_if.mem_addr    = mem_addr_q;
  assign arb_if.mem_we      = mem_we_q;
  assign arb_if.mem_din     = mem_din_q;
  assign arb_if.cpu_ack     = cpu_ack_q;
  assign arb_if.cpu_dout    = cpu_dout_q;
  assign arb_if.ldr_ack     = ldr_ack_q;
  assign arb_if.sav_ack     = sav_ack_q;
  assign arb_if.sav_dout    = sav_dout_q;
  assign arb_if.err_timeout = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: behavioural memory controller with
// programmable ack latency, grant/ack monitors and hand-computed expectations.
module tb_memory_arbiter;

  localparam int unsigned ADDR_W = 25;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [7:0]        din;
  } txn_t;

  logic clk;
  logic reset_n;

  memory_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  memory_arbiter #(
    .ADDR_W(ADDR_W),
    .CPU_BURST_MAX(4),
    .TIMEOUT(255)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .arb_if (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Controller model knobs: ack in cycle (ctl_wait+1) of mem_req
  int          ctl_wait  = 0;
  logic [7:0]  ctl_rdata = 8'h00;
  txn_t        log_q[$];

  // Monitor state
  int unsigned cyc        = 0;
  int unsigned n_cpu_ack  = 0;
  int unsigned n_ldr_ack  = 0;
  int unsigned n_sav_ack  = 0;
  int unsigned n_req_cyc  = 0;
  int unsigned gnt_addr_q[$];
  int unsigned gnt_cyc_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory controller model
  initial begin
    int busy;
    txn_t t;
    busy         = 0;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        busy++;
        if (busy == ctl_wait + 1) begin
          bus.mem_ack  = 1'b1;
          bus.mem_dout = ctl_rdata;
          t.addr = bus.mem_addr;
          t.we   = bus.mem_we;
          t.din  = bus.mem_din;
          log_q.push_back(t);
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Ack / grant monitor, sampled on the falling edge
  initial begin
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_ack === 1'b1) n_cpu_ack++;
      if (bus.ldr_ack === 1'b1) n_ldr_ack++;
      if (bus.sav_ack === 1'b1) n_sav_ack++;
      if (bus.mem_req === 1'b1) n_req_cyc++;
      if (bus.mem_req === 1'b1 && req_prev !== 1'b1) begin
        gnt_addr_q.push_back(32'(bus.mem_addr));
        gnt_cyc_q.push_back(cyc);
      end
      req_prev = bus.mem_req;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    bus.cpu_req  = 1'b0; bus.cpu_addr = '0; bus.cpu_rnw = 1'b1; bus.cpu_din = 8'h00;
    bus.ldr_req  = 1'b0; bus.ldr_addr = '0; bus.ldr_din = 8'h00;
    bus.sav_req  = 1'b0; bus.sav_addr = '0; bus.sav_rnw = 1'b1; bus.sav_din = 8'h00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ch: 0 cpu, 1 loader, 2 save. Returns the channel's dout at the ack cycle.
  task automatic wait_ack(input int ch, input int limit, output logic [7:0] dout);
    bit seen;
    seen = 1'b0;
    dout = 8'h00;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk);
      #1;
      case (ch)
        0: if (bus.cpu_ack === 1'b1) begin seen = 1'b1; dout = bus.cpu_dout; end
        1: if (bus.ldr_ack === 1'b1) seen = 1'b1;
        default: if (bus.sav_ack === 1'b1) begin seen = 1'b1; dout = bus.sav_dout; end
      endcase
    end
    if (!seen) chk("ack_wait", 32'd0, 32'd1);
  endtask

  task automatic cpu_txn(input logic [ADDR_W-1:0] a, input logic rnw, input logic [7:0] d,
                         output logic [7:0] dout);
    bus.cpu_addr = a; bus.cpu_rnw = rnw; bus.cpu_din = d; bus.cpu_req = 1'b1;
    wait_ack(0, 400, dout);
    bus.cpu_req = 1'b0;
  endtask

  task automatic ldr_txn(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    logic [7:0] unused;
    bus.ldr_addr = a; bus.ldr_din = d; bus.ldr_req = 1'b1;
    wait_ack(1, 400, unused);
    bus.ldr_req = 1'b0;
  endtask

  task automatic sav_txn(input logic [ADDR_W-1:0] a, input logic rnw, input logic [7:0] d,
                         output logic [7:0] dout);
    bus.sav_addr = a; bus.sav_rnw = rnw; bus.sav_din = d; bus.sav_req = 1'b1;
    wait_ack(2, 400, dout);
    bus.sav_req = 1'b0;
  endtask

  initial begin
    logic [7:0]  rd;
    int unsigned b_ack, b_req, b_gnt, b_log;
    int unsigned exp_seq [15];
    exp_seq = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200,
                32'h100, 32'h100, 32'h100, 32'h100, 32'h300,
                32'h100, 32'h100, 32'h100, 32'h100, 32'h200};

    // Reset state
    do_reset();
    chk("rst_mem_req",  32'(bus.mem_req),     32'd0);
    chk("rst_mem_we",   32'(bus.mem_we),      32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr),    32'd0);
    chk("rst_mem_din",  32'(bus.mem_din),     32'd0);
    chk("rst_acks",     32'({bus.cpu_ack, bus.ldr_ack, bus.sav_ack}), 32'd0);
    chk("rst_err",      32'(bus.err_timeout), 32'd0);
    chk("rst_cpu_dout", 32'(bus.cpu_dout),    32'd0);
    chk("rst_sav_dout", 32'(bus.sav_dout),    32'd0);

    // Single CPU read, ack after 3 wait cycles
    ctl_wait = 3; ctl_rdata = 8'h5A;
    b_ack = n_cpu_ack; b_req = n_req_cyc; b_log = log_q.size();
    cpu_txn(25'h001234, 1'b1, 8'h00, rd);
    chk("cpu_rd_req_low_at_ack", 32'(bus.mem_req), 32'd0);
    chk("cpu_rd_dout", 32'(rd), 32'h5A);
    repeat (3) @(posedge clk);
    #1;
    chk("cpu_rd_req_cycles", n_req_cyc - b_req, 32'd4);
    chk("cpu_rd_ack_pulses", n_cpu_ack - b_ack, 32'd1);
    chk("cpu_rd_cmd", {6'd0, log_q[b_log].we, log_q[b_log].addr}, 32'h0001234);
    chk("cpu_dout_held", 32'(bus.cpu_dout), 32'h5A);

    // All three requesters held: starvation guard and round-robin
    ctl_wait = 0; ctl_rdata = 8'h11;
    b_gnt = gnt_addr_q.size();
    bus.cpu_addr = 25'h100; bus.cpu_rnw = 1'b1;
    bus.ldr_addr = 25'h200; bus.ldr_din = 8'hC3;
    bus.sav_addr = 25'h300; bus.sav_rnw = 1'b1;
    bus.cpu_req = 1'b1; bus.ldr_req = 1'b1; bus.sav_req = 1'b1;
    for (int i = 0; i < 200 && (gnt_addr_q.size() < b_gnt + 15); i++) @(posedge clk);
    #1;
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0; bus.sav_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    if (gnt_addr_q.size() < b_gnt + 15) begin
      chk("rr_grant_count", 32'(gnt_addr_q.size() - b_gnt), 32'd15);
    end else begin
      for (int i = 0; i < 15; i++) begin
        chk($sformatf("rr_grant_%0d", i), gnt_addr_q[b_gnt + i], exp_seq[i]);
      end
      chk("rr_grant_spacing", gnt_cyc_q[b_gnt + 1] - gnt_cyc_q[b_gnt], 32'd3);
    end

    // Loader burst of 16 writes
    ctl_wait = 1;
    b_ack = n_ldr_ack; b_log = log_q.size();
    for (int i = 0; i < 16; i++) ldr_txn(ADDR_W'(i), 8'(i));
    repeat (2) @(posedge clk);
    #1;
    chk("ldr_ack_pulses", n_ldr_ack - b_ack, 32'd16);
    if (log_q.size() < b_log + 16) begin
      chk("ldr_log_count", 32'(log_q.size() - b_log), 32'd16);
    end else begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("ldr_wr_%0d", i),
            {log_q[b_log + i].we, log_q[b_log + i].din, log_q[b_log + i].addr[7:0]},
            {15'd0, 1'b1, 8'(i), 8'(i)});
      end
    end

    // Save read never acked: timeout
    ctl_wait = 1000;
    b_req = n_req_cyc; b_ack = n_sav_ack;
    sav_txn(25'h0ABCDE, 1'b1, 8'h00, rd);
    chk("tmo_req_low", 32'(bus.mem_req), 32'd0);
    chk("tmo_sav_dout", 32'(rd), 32'hFF);
    chk("tmo_err_set", 32'(bus.err_timeout), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("tmo_req_cycles", n_req_cyc - b_req, 32'd255);
    chk("tmo_ack_pulses", n_sav_ack - b_ack, 32'd1);
    ctl_wait = 1; ctl_rdata = 8'h3C;
    cpu_txn(25'h000777, 1'b1, 8'h00, rd);
    chk("post_tmo_cpu_dout", 32'(rd), 32'h3C);
    repeat (2) @(posedge clk);
    #1;
    chk("err_sticky", 32'(bus.err_timeout), 32'd1);

    // Ack in the last cycle before timeout
    do_reset();
    chk("rst_clears_err", 32'(bus.err_timeout), 32'd0);
    ctl_wait = 254; ctl_rdata = 8'h77;
    b_req = n_req_cyc;
    sav_txn(25'h000040, 1'b1, 8'h00, rd);
    chk("late_ack_sav_dout", 32'(rd), 32'h77);
    repeat (2) @(posedge clk);
    #1;
    chk("late_ack_no_err", 32'(bus.err_timeout), 32'd0);
    chk("late_ack_req_cycles", n_req_cyc - b_req, 32'd255);

    // Reset in the middle of a transaction
    ctl_wait = 1000;
    bus.cpu_addr = 25'h000999; bus.cpu_rnw = 1'b1; bus.cpu_req = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    chk("midbusy_req_before_rst", 32'(bus.mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midbusy_req_async_low", 32'(bus.mem_req), 32'd0);
    bus.cpu_req = 1'b0;
    b_ack = n_cpu_ack;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midbusy_no_ack", n_cpu_ack - b_ack, 32'd0);
    ctl_wait = 2;
    b_log = log_q.size();
    cpu_txn(25'h000055, 1'b0, 8'hA5, rd);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_cpu_ack", n_cpu_ack - b_ack, 32'd1);
    if (log_q.size() > b_log) begin
      chk("post_rst_cpu_wr", {log_q[b_log].we, log_q[b_log].din, log_q[b_log].addr[7:0]},
          {15'd0, 1'b1, 8'hA5, 8'h55});
    end else begin
      chk("post_rst_cpu_wr_logged", 32'd0, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
